plab5_mcore_mem_net_tdm_arb: RTL
================================

PLAB5_MCORE_MEM_NET_TDM_ARB -- requirements
Module: plab5_mcore_mem_net_tdm_arb

Interface
REQ-001 SHALL have parameter p_num_reqs, default 4: number of requesters (core-side request adapters).
REQ-002 SHALL have parameter p_msg_nbits, default 64: width of each network message.
REQ-003 SHALL have parameter p_domain_mask, default 4'b1010: bit i set means requester i is in domain 1; clear means domain 0.
REQ-004 SHALL have parameter p_slot_cycles, default 8: cycles per domain time slot.
REQ-005 SHALL have parameter p_guard_cycles, default 2: no-grant cycles at the end of each slot.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-008 SHALL have port in_val, input, p_num_reqs: per-requester valid.
REQ-009 SHALL have port in_rdy, output, p_num_reqs: per-requester ready.
REQ-010 SHALL have port in_msg, input, p_num_reqs*p_msg_nbits: requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
REQ-011 SHALL have port out_val, input-side valid to network, output, 1.
REQ-012 SHALL have port out_rdy, input, 1: network injection ready.
REQ-013 SHALL have port out_msg, output, p_msg_nbits: granted message.
REQ-014 SHALL have port out_domain, output, 1: current slot's domain; drives the adapters' sd input.

Function
REQ-015 SHALL keep slot counter slot_cnt, width $clog2(p_slot_cycles), incrementing every cycle, wrapping p_slot_cycles-1 -> 0.
REQ-016 SHALL toggle the domain register on the wrap cycle; out_domain is constant for all p_slot_cycles cycles of a slot.
REQ-017 SHALL implement FSM {ACTIVE, GUARD}: ACTIVE while slot_cnt < p_slot_cycles-p_guard_cycles; GUARD otherwise; GUARD -> ACTIVE on wrap.
REQ-018 SHALL define eligible[i] = in_val[i] & (p_domain_mask[i] == domain) & (state == ACTIVE).
REQ-019 SHALL grant, combinationally in the same cycle, the first eligible requester at or after the current domain's round-robin pointer, modulo p_num_reqs.
REQ-020 SHALL drive out_val = |eligible, out_msg = granted in_msg (all zeros when none is granted), and in_rdy[g] = out_rdy for grant g only; every other in_rdy bit is 0.
REQ-021 SHALL keep one round-robin pointer per domain; on out_val & out_rdy, the current domain's pointer becomes (g+1) mod p_num_reqs; the other pointer is unchanged.
REQ-022 SHALL make out_val, out_msg, in_rdy and timing independent of the in_val/in_msg of requesters outside the current domain (noninterference).
REQ-023 SHALL allow out_val to fall on GUARD entry while out_rdy is low; no message is lost, because transfer occurs only on val & rdy.
REQ-024 SHALL leave a slot idle if its domain has no requesters (mask all zeros or all ones); slot timing is unchanged.
REQ-025 SHALL require 2 <= p_slot_cycles and 0 <= p_guard_cycles < p_slot_cycles; with p_guard_cycles = 0, GUARD is never entered.
REQ-026 SHALL have zero latency: out_msg equals the granted in_msg in the same cycle; no internal storage of messages.

Reset
REQ-027 SHALL, when reset is 0 at a clk edge, set slot_cnt = 0, domain = 0, state = ACTIVE, and both pointers = 0.
REQ-028 SHALL, during reset, force out_val = 0 and in_rdy = 0; out_domain = 0.
REQ-029 SHALL, on reset mid-slot, restart at slot 0 / domain 0 on the first cycle after reset returns to 1; pointer history is discarded.

Structure
REQ-030 SHALL take message field macros from vc-net-msgs.v; no new shared header is added; domain encodings 0/1 are local constants.
REQ-031 SHALL place slot_cnt, domain and the FSM in one sub-module, plab5_mcore_tdm_slot_timer, outputting domain and active.

Verification
REQ-032 Reset held for 3 cycles, with all in_val = 1 -> out_val = 0 and in_rdy = 0; after release, out_domain = 0 and slot_cnt = 0.
REQ-033 Defaults, reqs 0 and 2 always valid, out_rdy = 1 -> grants 0,2,0,2,0,2 in cycles 0-5; cycles 6-7 out_val = 0; cycles 8-15 out_domain = 1 with no grants.
REQ-034 Reqs 1 and 3 valid, mask 4'b1010 -> no grant in cycles 0-7; grants 1,3,1,3,1,3 in cycles 8-13; out_val = 0 in cycles 14-15.
REQ-035 Rerun REQ-033 with reqs 1 and 3 toggling randomly -> domain-0 grant trace and out_val trace are bit-identical to the original run.
REQ-036 Req 0 valid, out_rdy = 0 in cycles 0-5, then 1 -> out_val = 1 in cycles 0-5 and 0 in cycles 6-7; req 0 transfers at cycle 16; pointer = 1 afterward.
REQ-037 Reset asserted at cycle 11 (domain 1 active) -> after release, out_domain = 0, slot_cnt = 0, and domain-1 pointer = 0.

Source files
------------

// File: rtl/plab5_mcore_mem_net_tdm_arb_pkg.sv
// rtl/plab5_mcore_mem_net_tdm_arb_pkg.sv - shared types and constants for the TDM memory-network arbiter
//
// Purpose: slot FSM state encoding, security-domain encodings and a small
// width helper used by the slot timer and the arbiter top.
package plab5_mcore_mem_net_tdm_arb_pkg;

  // Slot FSM: grants are only possible in ACTIVE; GUARD drains the slot.
  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GUARD  = 1'b1
  } tdm_state_e;

  // Domain encodings are local to this block; they match p_domain_mask bits.
  localparam logic DOMAIN_0 = 1'b0;
  localparam logic DOMAIN_1 = 1'b1;

  // Index/counter width that stays legal for a count of 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_tdm_arb_if.sv
// rtl/plab5_mcore_mem_net_tdm_arb_if.sv - requester/network handshake bundle for the TDM arbiter
//
// Purpose: groups the per-requester val/rdy/msg inputs and the single
// network injection port.
// Signals:
//   in_val[p_num_reqs]              requester valid
//   in_rdy[p_num_reqs]              requester ready (one-hot or zero)
//   in_msg[p_num_reqs*p_msg_nbits]  requester i at [i*p_msg_nbits +: p_msg_nbits]
//   out_val / out_rdy / out_msg     network injection handshake
//   out_domain                      current slot's domain (adapters' sd input)
// Modports: master = arbiter side, slave = requesters + network side.
interface plab5_mcore_mem_net_tdm_arb_if #(
  parameter int p_num_reqs  = 4,
  parameter int p_msg_nbits = 64
);
  logic [p_num_reqs-1:0]             in_val;
  logic [p_num_reqs-1:0]             in_rdy;
  logic [p_num_reqs*p_msg_nbits-1:0] in_msg;
  logic                              out_val;
  logic                              out_rdy;
  logic [p_msg_nbits-1:0]            out_msg;
  logic                              out_domain;

  modport master (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_domain
  );

  modport slave (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_domain
  );
endinterface

// File: rtl/plab5_mcore_tdm_slot_timer.sv
// rtl/plab5_mcore_tdm_slot_timer.sv - slot counter, domain register and ACTIVE/GUARD FSM
//
// Purpose: divides time into p_slot_cycles-long slots that alternate between
// domain 0 and domain 1; the last p_guard_cycles cycles of each slot are GUARD.
// Ports:
//   clk, reset (sync, active-low)
//   domain    current slot's domain (constant for the whole slot)
//   active    1 while the FSM is in ACTIVE
//   slot_cnt  position within the slot, 0 .. p_slot_cycles-1
module plab5_mcore_tdm_slot_timer
  import plab5_mcore_mem_net_tdm_arb_pkg::*;
#(
  parameter int p_slot_cycles  = 8,
  parameter int p_guard_cycles = 2,
  localparam int CW = idx_width(p_slot_cycles)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          domain,
  output logic          active,
  output logic [CW-1:0] slot_cnt
);

  tdm_state_e state;
  logic       wrap;

  assign wrap   = (slot_cnt == CW'(p_slot_cycles - 1));
  assign active = (state == ST_ACTIVE);

  // State is computed from the *next* slot_cnt so that it always agrees with
  // "ACTIVE iff slot_cnt < p_slot_cycles - p_guard_cycles" in the same cycle.
  // With p_guard_cycles == 0 the threshold is never reached before the wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt <= '0;
      domain   <= DOMAIN_0;
      state    <= ST_ACTIVE;
    end else if (wrap) begin
      slot_cnt <= '0;
      domain   <= (domain == DOMAIN_0) ? DOMAIN_1 : DOMAIN_0;
      state    <= ST_ACTIVE;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (int'(slot_cnt) + 1 >= p_slot_cycles - p_guard_cycles)
        state <= ST_GUARD;
      else
        state <= ST_ACTIVE;
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_net_tdm_arb.sv
// rtl/plab5_mcore_mem_net_tdm_arb.sv - time-division-multiplexed two-domain round-robin arbiter
//
// Purpose: zero-latency arbiter that lets only the requesters of the current
// slot's domain compete for the network, with a per-domain round-robin
// pointer, so one domain cannot influence the other's timing.
// Ports:
//   clk, reset (sync, active-low)
//   bus  (master modport): in_val/in_rdy/in_msg per requester,
//        out_val/out_rdy/out_msg to the network, out_domain to adapters
module plab5_mcore_mem_net_tdm_arb
  import plab5_mcore_mem_net_tdm_arb_pkg::*;
#(
  parameter int                    p_num_reqs     = 4,
  parameter int                    p_msg_nbits    = 64,
  parameter logic [p_num_reqs-1:0] p_domain_mask  = 4'b1010,
  parameter int                    p_slot_cycles  = 8,
  parameter int                    p_guard_cycles = 2
) (
  input logic                          clk,
  input logic                          reset,
  plab5_mcore_mem_net_tdm_arb_if.master bus
);

  localparam int PW = idx_width(p_num_reqs);
  localparam int CW = idx_width(p_slot_cycles);

  logic                      domain;
  logic                      active;
  logic [CW-1:0]             slot_cnt;
  logic [p_num_reqs-1:0]     eligible;
  logic [1:0][PW-1:0]        rr_ptr;
  logic [PW-1:0]             cur_ptr;
  logic                      grant_val;
  logic [PW-1:0]             grant_idx;
  logic [PW-1:0]             next_ptr;

  plab5_mcore_tdm_slot_timer #(
    .p_slot_cycles  (p_slot_cycles),
    .p_guard_cycles (p_guard_cycles)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .domain   (domain),
    .active   (active),
    .slot_cnt (slot_cnt)
  );

  // Requesters outside the current domain are masked here, before the
  // priority search, so their val/msg never reach any output.
  // Qualifying with reset keeps every handshake output low while in reset.
  for (genvar i = 0; i < p_num_reqs; i++) begin : g_elig
    assign eligible[i] = bus.in_val[i] & (p_domain_mask[i] == domain)
                       & active & reset;
  end

  assign cur_ptr = rr_ptr[domain];

  // First eligible requester at or after the pointer, modulo p_num_reqs.
  always_comb begin
    int idx;
    grant_val = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = int'(cur_ptr) + k;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      if (!grant_val && eligible[PW'(idx)]) begin
        grant_val = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  assign next_ptr = (grant_idx == PW'(p_num_reqs - 1)) ? '0 : grant_idx + 1'b1;

  assign bus.out_val    = grant_val;
  assign bus.out_domain = reset & domain;
  assign bus.out_msg    = grant_val
                        ? bus.in_msg[int'(grant_idx)*p_msg_nbits +: p_msg_nbits]
                        : '0;

  always_comb begin
    bus.in_rdy = '0;
    if (grant_val) bus.in_rdy[grant_idx] = bus.out_rdy;
  end

  // Only the owning domain's pointer moves, and only on an actual transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_val && bus.out_rdy) begin
      rr_ptr[domain] <= next_ptr;
    end
  end

endmodule
